// File: rtl/vscale_fetch_redirect_ctrl_pkg.sv
// Shared select/state encodings for the fetch-redirect controller.
package vscale_fetch_redirect_ctrl_pkg;

  localparam int unsigned PC_SRC_SEL_WIDTH = 3;
  typedef logic [PC_SRC_SEL_WIDTH-1:0] pc_sel_t;

  localparam pc_sel_t PC_PLUS_FOUR     = 3'd0;
  localparam pc_sel_t PC_BRANCH_TARGET = 3'd1;
  localparam pc_sel_t PC_JAL_TARGET    = 3'd2;
  localparam pc_sel_t PC_JALR_TARGET   = 3'd3;
  localparam pc_sel_t PC_REPLAY        = 3'd4;
  localparam pc_sel_t PC_HANDLER       = 3'd5;
  localparam pc_sel_t PC_EPC           = 3'd6;

  localparam int unsigned FETCH_STATE_WIDTH = 2;
  typedef enum logic [FETCH_STATE_WIDTH-1:0] {
    FETCH_BOOT = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HOLD = 2'd2
  } fetch_state_e;

  // Arbitration rank of a redirect select; non-redirects rank lowest.
  function automatic logic [2:0] sel_rank(input pc_sel_t sel);
    case (sel)
      PC_HANDLER:       sel_rank = 3'd5;
      PC_EPC:           sel_rank = 3'd4;
      PC_JALR_TARGET:   sel_rank = 3'd3;
      PC_JAL_TARGET:    sel_rank = 3'd2;
      PC_BRANCH_TARGET: sel_rank = 3'd1;
      default:          sel_rank = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/vscale_redirect_prio.sv
// Combinational priority encoder for PC-source requests.
module vscale_redirect_prio
  import vscale_fetch_redirect_ctrl_pkg::*;
(
  input  logic    exception_WB,
  input  logic    eret_WB,
  input  logic    jalr_DX,
  input  logic    jal_DX,
  input  logic    branch_taken_DX,
  input  logic    stall_ext,
  input  logic    imem_wait,
  output pc_sel_t sel,
  output logic    is_redirect,
  output pc_sel_t wb_sel,
  output logic    wb_valid
);

  always_comb begin
    sel         = PC_PLUS_FOUR;
    is_redirect = 1'b1;
    if (exception_WB) begin
      sel = PC_HANDLER;
    end else if (eret_WB) begin
      sel = PC_EPC;
    end else if (jalr_DX) begin
      sel = PC_JALR_TARGET;
    end else if (jal_DX) begin
      sel = PC_JAL_TARGET;
    end else if (branch_taken_DX) begin
      sel = PC_BRANCH_TARGET;
    end else begin
      is_redirect = 1'b0;
      sel         = (stall_ext || imem_wait) ? PC_REPLAY : PC_PLUS_FOUR;
    end
  end

  // WB-only winner, used to override a held DX redirect.
  assign wb_valid = exception_WB | eret_WB;
  assign wb_sel   = exception_WB ? PC_HANDLER : PC_EPC;

endmodule

// File: rtl/vscale_fetch_redirect_ctrl.sv
// Fetch-redirect controller driving the PC mux select; holds redirects while imem is busy.
// Optional redirect counter enabled by defining VSCALE_REDIRECT_CNT_EN.
module vscale_fetch_redirect_ctrl
  import vscale_fetch_redirect_ctrl_pkg::*;
(
  input  logic    clk,
  input  logic    reset_n,
  input  logic    exception_WB,
  input  logic    eret_WB,
  input  logic    jalr_DX,
  input  logic    jal_DX,
  input  logic    branch_taken_DX,
  input  logic    stall_ext,
  input  logic    imem_wait,
  output pc_sel_t PC_src_sel,
  output logic    kill_IF,
  output logic    stall_IF,
  output logic    hold_DX
`ifdef VSCALE_REDIRECT_CNT_EN
  ,
  output logic [31:0] redirect_count
`endif
);

  fetch_state_e r_state, w_state_nxt;
  pc_sel_t      r_held_sel, w_held_nxt;
  pc_sel_t      w_win_sel, w_wb_sel;
  logic         w_is_redirect, w_wb_valid, w_override;

  vscale_redirect_prio u_prio (
    .exception_WB    (exception_WB),
    .eret_WB         (eret_WB),
    .jalr_DX         (jalr_DX),
    .jal_DX          (jal_DX),
    .branch_taken_DX (branch_taken_DX),
    .stall_ext       (stall_ext),
    .imem_wait       (imem_wait),
    .sel             (w_win_sel),
    .is_redirect     (w_is_redirect),
    .wb_sel          (w_wb_sel),
    .wb_valid        (w_wb_valid)
  );

  // A held redirect yields only to a strictly higher-priority WB request.
  assign w_override = (r_state == FETCH_HOLD) && w_wb_valid &&
                      (sel_rank(w_wb_sel) > sel_rank(r_held_sel));

  always_comb begin
    w_state_nxt = r_state;
    w_held_nxt  = r_held_sel;
    PC_src_sel  = PC_REPLAY;
    kill_IF     = 1'b1;
    stall_IF    = 1'b0;
    hold_DX     = 1'b0;
    case (r_state)
      FETCH_BOOT: begin
        w_state_nxt = FETCH_RUN;
      end
      FETCH_RUN: begin
        PC_src_sel = w_win_sel;
        if (w_is_redirect) begin
          if (imem_wait) begin
            hold_DX     = 1'b1;
            w_held_nxt  = w_win_sel;
            w_state_nxt = FETCH_HOLD;
          end
        end else begin
          kill_IF  = 1'b0;
          stall_IF = stall_ext | imem_wait;
        end
      end
      FETCH_HOLD: begin
        hold_DX    = 1'b1;
        PC_src_sel = r_held_sel;
        if (w_override) begin
          PC_src_sel = w_wb_sel;
          w_held_nxt = w_wb_sel;
        end
        if (!imem_wait) begin
          w_state_nxt = FETCH_RUN;
        end
      end
      default: begin
        w_state_nxt = FETCH_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= FETCH_BOOT;
      r_held_sel <= PC_PLUS_FOUR;
    end else begin
      r_state    <= w_state_nxt;
      r_held_sel <= w_held_nxt;
    end
  end

`ifdef VSCALE_REDIRECT_CNT_EN
  logic        w_accept;
  logic [31:0] r_count;

  assign w_accept = ((r_state == FETCH_RUN) && w_is_redirect) || w_override;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= 32'd0;
    end else if (w_accept) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign redirect_count = r_count;
`endif

endmodule

// File: tb/tb_vscale_fetch_redirect_ctrl.sv
// Self-checking bench for vscale_fetch_redirect_ctrl; counter checks need VSCALE_REDIRECT_CNT_EN.
`timescale 1ns/1ps
module tb_vscale_fetch_redirect_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       exception_WB = 1'b0, eret_WB = 1'b0, jalr_DX = 1'b0, jal_DX = 1'b0;
  logic       branch_taken_DX = 1'b0, stall_ext = 1'b0, imem_wait = 1'b0;
  logic [2:0] PC_src_sel;
  logic       kill_IF, stall_IF, hold_DX;
`ifdef VSCALE_REDIRECT_CNT_EN
  logic [31:0] redirect_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  vscale_fetch_redirect_ctrl dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .exception_WB    (exception_WB),
    .eret_WB         (eret_WB),
    .jalr_DX         (jalr_DX),
    .jal_DX          (jal_DX),
    .branch_taken_DX (branch_taken_DX),
    .stall_ext       (stall_ext),
    .imem_wait       (imem_wait),
    .PC_src_sel      (PC_src_sel),
    .kill_IF         (kill_IF),
    .stall_IF        (stall_IF),
    .hold_DX         (hold_DX)
`ifdef VSCALE_REDIRECT_CNT_EN
    ,
    .redirect_count  (redirect_count)
`endif
  );

  always #5 clk = ~clk;

  // Input vector bit order.
  localparam int EXC = 6, ERET = 5, JALR = 4, JAL = 3, BR = 2, STL = 1, IMW = 0;

  // Reference model: pending-redirect bookkeeping from the arbitration rules.
  int          prio_sel [5] = '{5, 6, 3, 2, 1};
  bit          m_boot, m_hold, m_ovr;
  int          m_held, m_win;
  logic [31:0] m_cnt;
  logic [2:0]  e_sel;
  logic        e_kill, e_stall, e_hold;

  function automatic int rank_of(input int s);
    for (int i = 0; i < 5; i++) if (prio_sel[i] == s) return 5 - i;
    return 0;
  endfunction

  task automatic model_reset();
    m_boot = 1'b1; m_hold = 1'b0; m_held = 0; m_cnt = 32'd0; m_ovr = 1'b0; m_win = -1;
  endtask

  task automatic model_eval();
    logic [4:0] req;
    int wbwin;
    req   = {exception_WB, eret_WB, jalr_DX, jal_DX, branch_taken_DX};
    m_win = -1;
    wbwin = -1;
    for (int i = 0; i < 5; i++) if (req[4-i] && m_win < 0) m_win = prio_sel[i];
    for (int i = 0; i < 2; i++) if (req[4-i] && wbwin < 0) wbwin = prio_sel[i];
    m_ovr = 1'b0;
    if (!reset_n || m_boot) begin
      e_sel = 3'd4; e_kill = 1'b1; e_stall = 1'b0; e_hold = 1'b0;
    end else if (m_hold) begin
      e_sel = 3'(m_held); e_kill = 1'b1; e_stall = 1'b0; e_hold = 1'b1;
      if (wbwin >= 0 && rank_of(wbwin) > rank_of(m_held)) begin
        e_sel = 3'(wbwin); m_ovr = 1'b1;
      end
    end else if (m_win >= 0) begin
      e_sel = 3'(m_win); e_kill = 1'b1; e_stall = 1'b0; e_hold = imem_wait;
    end else if (stall_ext || imem_wait) begin
      e_sel = 3'd4; e_kill = 1'b0; e_stall = 1'b1; e_hold = 1'b0;
    end else begin
      e_sel = 3'd0; e_kill = 1'b0; e_stall = 1'b0; e_hold = 1'b0;
    end
  endtask

  task automatic model_update();
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_hold) begin
      if (m_ovr) begin m_held = int'(e_sel); m_cnt = m_cnt + 32'd1; end
      if (!imem_wait) m_hold = 1'b0;
    end else if (m_win >= 0) begin
      m_cnt = m_cnt + 32'd1;
      if (imem_wait) begin m_hold = 1'b1; m_held = m_win; end
    end
  endtask

  task automatic drive(input logic [6:0] v);
    @(negedge clk);
    {exception_WB, eret_WB, jalr_DX, jal_DX, branch_taken_DX, stall_ext, imem_wait} = v;
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_update();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    {exception_WB, eret_WB, jalr_DX, jal_DX, branch_taken_DX, stall_ext, imem_wait} = 7'd0;
    model_reset();
    #1;
    n_checks++; if (PC_src_sel !== 3'd4 || kill_IF !== 1'b1 || stall_IF !== 1'b0 || hold_DX !== 1'b0) begin
      n_errors++; $display("FAIL reset_outputs: got sel=%0d kill=%b stall=%b hold=%b, want 4 1 0 0",
                           PC_src_sel, kill_IF, stall_IF, hold_DX); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_checks++; if (PC_src_sel !== 3'd4 || kill_IF !== 1'b1) begin
      n_errors++; $display("FAIL boot_outputs: got sel=%0d kill=%b, want 4 1", PC_src_sel, kill_IF); end
    tick();
    tick();
    drive(7'd0);
    n_checks++; if (PC_src_sel !== 3'd0 || kill_IF !== 1'b0 || stall_IF !== 1'b0 || hold_DX !== 1'b0) begin
      n_errors++; $display("FAIL run_idle: got sel=%0d kill=%b stall=%b hold=%b, want 0 0 0 0",
                           PC_src_sel, kill_IF, stall_IF, hold_DX); end
`ifdef VSCALE_REDIRECT_CNT_EN
    n_checks++; if (redirect_count !== 32'd0) begin
      n_errors++; $display("FAIL reset_count: got %0d want 0", redirect_count); end
`endif
    tick();
  endtask

  task automatic test_branch();
    logic [31:0] c0;
    c0 = m_cnt;
    drive(7'b1 << BR);
    n_checks++; if (PC_src_sel !== 3'd1 || kill_IF !== 1'b1 || hold_DX !== 1'b0) begin
      n_errors++; $display("FAIL branch_sel: got sel=%0d kill=%b hold=%b, want 1 1 0",
                           PC_src_sel, kill_IF, hold_DX); end
    tick();
    drive(7'd0);
    n_checks++; if (PC_src_sel !== 3'd0 || kill_IF !== 1'b0) begin
      n_errors++; $display("FAIL branch_after: got sel=%0d kill=%b, want 0 0", PC_src_sel, kill_IF); end
`ifdef VSCALE_REDIRECT_CNT_EN
    n_checks++; if (redirect_count !== c0 + 32'd1) begin
      n_errors++; $display("FAIL branch_count: got %0d want %0d", redirect_count, c0 + 32'd1); end
`endif
    tick();
  endtask

  task automatic test_jalr_hold();
    logic [31:0] c0;
    logic [6:0]  v;
    c0 = m_cnt;
    for (int i = 0; i < 4; i++) begin
      // DX/stall noise during HOLD must be ignored.
      v = (i == 0) ? ((7'b1 << JALR) | (7'b1 << IMW))
                   : ((7'b1 << JAL) | (7'b1 << STL) | ((i < 3) ? (7'b1 << IMW) : 7'd0));
      drive(v);
      n_checks++; if (PC_src_sel !== 3'd3 || hold_DX !== 1'b1 || kill_IF !== 1'b1) begin
        n_errors++; $display("FAIL jalr_hold[%0d]: got sel=%0d hold=%b kill=%b, want 3 1 1",
                             i, PC_src_sel, hold_DX, kill_IF); end
      tick();
    end
    drive(7'd0);
    n_checks++; if (PC_src_sel !== 3'd0 || hold_DX !== 1'b0 || kill_IF !== 1'b0) begin
      n_errors++; $display("FAIL jalr_release: got sel=%0d hold=%b kill=%b, want 0 0 0",
                           PC_src_sel, hold_DX, kill_IF); end
`ifdef VSCALE_REDIRECT_CNT_EN
    n_checks++; if (redirect_count !== c0 + 32'd1) begin
      n_errors++; $display("FAIL jalr_count: got %0d want %0d", redirect_count, c0 + 32'd1); end
`endif
    tick();
  endtask

  task automatic test_hold_override();
    logic [31:0] c0;
    c0 = m_cnt;
    drive((7'b1 << JAL) | (7'b1 << IMW));
    n_checks++; if (PC_src_sel !== 3'd2 || hold_DX !== 1'b1) begin
      n_errors++; $display("FAIL ovr_jal: got sel=%0d hold=%b, want 2 1", PC_src_sel, hold_DX); end
    tick();
    drive((7'b1 << EXC) | (7'b1 << IMW));
    n_checks++; if (PC_src_sel !== 3'd5 || hold_DX !== 1'b1 || kill_IF !== 1'b1) begin
      n_errors++; $display("FAIL ovr_exc: got sel=%0d hold=%b kill=%b, want 5 1 1",
                           PC_src_sel, hold_DX, kill_IF); end
    tick();
    drive(7'b1 << IMW);
    n_checks++; if (PC_src_sel !== 3'd5) begin
      n_errors++; $display("FAIL ovr_relatched: got sel=%0d want 5", PC_src_sel); end
    tick();
    // Lower-priority eret must not displace a held HANDLER.
    drive(7'b1 << ERET);
    n_checks++; if (PC_src_sel !== 3'd5 || hold_DX !== 1'b1) begin
      n_errors++; $display("FAIL ovr_eret_low: got sel=%0d hold=%b, want 5 1", PC_src_sel, hold_DX); end
    tick();
    drive(7'd0);
    n_checks++; if (PC_src_sel !== 3'd0 || hold_DX !== 1'b0) begin
      n_errors++; $display("FAIL ovr_release: got sel=%0d hold=%b, want 0 0", PC_src_sel, hold_DX); end
`ifdef VSCALE_REDIRECT_CNT_EN
    n_checks++; if (redirect_count !== c0 + 32'd2) begin
      n_errors++; $display("FAIL ovr_count: got %0d want %0d", redirect_count, c0 + 32'd2); end
`endif
    tick();
  endtask

  task automatic test_stall_eret();
    drive(7'b1 << STL);
    n_checks++; if (PC_src_sel !== 3'd4 || stall_IF !== 1'b1 || kill_IF !== 1'b0 || hold_DX !== 1'b0) begin
      n_errors++; $display("FAIL stall_ext: got sel=%0d stall=%b kill=%b hold=%b, want 4 1 0 0",
                           PC_src_sel, stall_IF, kill_IF, hold_DX); end
    tick();
    drive(7'b1 << IMW);
    n_checks++; if (PC_src_sel !== 3'd4 || stall_IF !== 1'b1 || kill_IF !== 1'b0) begin
      n_errors++; $display("FAIL stall_imem: got sel=%0d stall=%b kill=%b, want 4 1 0",
                           PC_src_sel, stall_IF, kill_IF); end
    tick();
    drive((7'b1 << ERET) | (7'b1 << JAL));
    n_checks++; if (PC_src_sel !== 3'd6 || kill_IF !== 1'b1) begin
      n_errors++; $display("FAIL eret_jal: got sel=%0d kill=%b, want 6 1", PC_src_sel, kill_IF); end
    tick();
    drive((7'b1 << EXC) | (7'b1 << JAL) | (7'b1 << STL));
    n_checks++; if (PC_src_sel !== 3'd5 || kill_IF !== 1'b1) begin
      n_errors++; $display("FAIL exc_jal: got sel=%0d kill=%b, want 5 1", PC_src_sel, kill_IF); end
    tick();
  endtask

  task automatic test_reset_mid_hold();
    drive((7'b1 << BR) | (7'b1 << IMW));
    tick();
    drive(7'b1 << IMW);
    n_checks++; if (PC_src_sel !== 3'd1 || hold_DX !== 1'b1) begin
      n_errors++; $display("FAIL rst_hold_pre: got sel=%0d hold=%b, want 1 1", PC_src_sel, hold_DX); end
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (PC_src_sel !== 3'd4 || kill_IF !== 1'b1 || stall_IF !== 1'b0 || hold_DX !== 1'b0) begin
      n_errors++; $display("FAIL rst_hold_async: got sel=%0d kill=%b stall=%b hold=%b, want 4 1 0 0",
                           PC_src_sel, kill_IF, stall_IF, hold_DX); end
`ifdef VSCALE_REDIRECT_CNT_EN
    n_checks++; if (redirect_count !== 32'd0) begin
      n_errors++; $display("FAIL rst_hold_count: got %0d want 0", redirect_count); end
`endif
    @(negedge clk);
    imem_wait = 1'b0;
    reset_n   = 1'b1;
    tick();
    tick();
    drive(7'd0);
    n_checks++; if (PC_src_sel !== 3'd0 || hold_DX !== 1'b0) begin
      n_errors++; $display("FAIL rst_hold_resume: got sel=%0d hold=%b, want 0 0", PC_src_sel, hold_DX); end
    tick();
  endtask

  task automatic test_random();
    logic [6:0] v;
    for (int n = 0; n < 400; n++) begin
      v[EXC]  = ($urandom_range(0, 11) == 0);
      v[ERET] = ($urandom_range(0, 9) == 0);
      v[JALR] = ($urandom_range(0, 7) == 0);
      v[JAL]  = ($urandom_range(0, 7) == 0);
      v[BR]   = ($urandom_range(0, 5) == 0);
      v[STL]  = ($urandom_range(0, 3) == 0);
      v[IMW]  = ($urandom_range(0, 7) < 3);
      drive(v);
      n_checks++; if (PC_src_sel !== e_sel || kill_IF !== e_kill || hold_DX !== e_hold ||
                      (!e_kill && stall_IF !== e_stall)) begin
        n_errors++; $display("FAIL random[%0d] in=%b: got sel=%0d kill=%b stall=%b hold=%b, want %0d %b %b %b",
                             n, v, PC_src_sel, kill_IF, stall_IF, hold_DX, e_sel, e_kill, e_stall, e_hold); end
`ifdef VSCALE_REDIRECT_CNT_EN
      n_checks++; if (redirect_count !== m_cnt) begin
        n_errors++; $display("FAIL random_count[%0d]: got %0d want %0d", n, redirect_count, m_cnt); end
`endif
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jalr_hold();
    test_hold_override();
    test_stall_eret();
    test_reset_mid_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vscale_fetch_redirect_ctrl.md
# vscale_fetch_redirect_ctrl

Fetch-redirect controller that produces `PC_src_sel` for the PC mux each cycle. It arbitrates among trap, exception-return, jump/branch and stall requests, and kills the in-flight IF instruction on a redirect. When the instruction memory is busy, it holds an accepted redirect until the fetch is actually issued. It sits between the pipeline control logic and the PC mux in the core front end.

## Interface
Parameters:
- none; all widths and encodings come from `vscale_ctrl_constants.vh`.

Ports:
- `clk`  in  1  core clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `exception_WB`  in  1  trap taken in WB; requests `PC_HANDLER`.
- `eret_WB`  in  1  exception return in WB; requests `PC_EPC`.
- `jalr_DX`  in  1  valid JALR in DX.
- `jal_DX`  in  1  valid JAL in DX.
- `branch_taken_DX`  in  1  resolved taken branch in DX.
- `stall_ext`  in  1  hazard or dmem stall; IF must replay.
- `imem_wait`  in  1  instruction memory not accepting a fetch this cycle.
- `PC_src_sel`  out  `PC_SRC_SEL_WIDTH`(3)  select to the PC mux.
- `kill_IF`  out  1  squash the instruction currently in IF.
- `stall_IF`  out  1  hold the IF stage registers.
- `hold_DX`  out  1  freeze DX so the held redirect target stays valid.
- `redirect_count`  out  32  only when `VSCALE_REDIRECT_CNT_EN` is defined.

## Operation
Select encodings:
- `PC_PLUS_FOUR`=0, `PC_BRANCH_TARGET`=1, `PC_JAL_TARGET`=2, `PC_JALR_TARGET`=3, `PC_REPLAY`=4, `PC_HANDLER`=5, `PC_EPC`=6.

Request priority, highest first:
- `exception_WB` > `eret_WB` > `jalr_DX` > `jal_DX` > `branch_taken_DX` > `stall_ext`/`imem_wait` (both give `PC_REPLAY`) > `PC_PLUS_FOUR`.
- A "redirect" is any selection of 1, 2, 3, 5 or 6.

States (2-bit register): BOOT, RUN, HOLD.
- BOOT:
  - Outputs: `PC_src_sel`=REPLAY, `kill_IF`=1, `stall_IF`=0, `hold_DX`=0.
  - Always moves to RUN on the next edge.
- RUN:
  - `PC_src_sel` is the priority winner.
  - Redirect with `imem_wait`=0: `kill_IF`=1; stay in RUN.
  - Redirect with `imem_wait`=1: latch the selection into `held_sel`, `kill_IF`=1, `hold_DX`=1; go to HOLD.
  - No redirect with `stall_ext` or `imem_wait` high: `PC_src_sel`=REPLAY, `stall_IF`=1.
- HOLD:
  - Outputs: `PC_src_sel`=`held_sel`, `kill_IF`=1, `hold_DX`=1.
  - `exception_WB`/`eret_WB` override `held_sel` only if higher priority; the new select is output and re-latched.
  - DX requests and `stall_ext` are ignored.
  - `imem_wait`=0: the fetch issues with the current select; go to RUN.

Counter:
- `redirect_count` increments by 1 per accepted redirect: a RUN-cycle redirect, or a HOLD-cycle override.
- HOLD wait cycles do not count.
- Wraps modulo 2^32.

## Timing
- Reset: `reset_n` low forces state=BOOT and `held_sel`=0 immediately (asynchronous), with `redirect_count`=0.
  - Outputs while in reset: `PC_src_sel`=4, `kill_IF`=1, `stall_IF`=0, `hold_DX`=0.
  - The first RUN cycle is the second rising edge after `reset_n` rises.
- In RUN, all outputs are combinational from the inputs (zero latency).
- In HOLD, outputs depend on state and `held_sel`, plus the same-cycle `exception_WB`/`eret_WB` inputs.
- A redirect under `imem_wait` holds for N+1 cycles, where N is the number of consecutive `imem_wait`=1 cycles.
- Reset asserted while in HOLD discards the held redirect; no count increment occurs.
- `exception_WB` and `jal_DX` in the same cycle: HANDLER wins. `kill_IF`=1; DX squash is the caller's responsibility.

## Configuration
- `VSCALE_REDIRECT_CNT_EN` defined: the `redirect_count` port and its 32-bit counter exist.
- Undefined: no port and no counter; all other behaviour is identical.

## Structure
- Add to `vscale_ctrl_constants.vh`:
  - `PC_SRC_SEL_WIDTH` and all `PC_*` select encodings.
  - `FETCH_STATE_WIDTH` and the `FETCH_BOOT`/`FETCH_RUN`/`FETCH_HOLD` state encodings.
- One sub-module, `vscale_redirect_prio`: combinational priority encoder giving the winner select plus an `is_redirect` flag.
- State register, `held_sel` and the counter live in the top module.

## Test plan
- Reset release, no requests -> `PC_src_sel`=4 in BOOT, then 0 with `kill_IF`=0 from the second edge onward.
- `branch_taken_DX`=1, `imem_wait`=0 -> `PC_src_sel`=1, `kill_IF`=1 for one cycle, `redirect_count` +1.
- `jalr_DX`=1 with `imem_wait`=1 for 3 cycles -> sel=3 and `hold_DX`=1 for 4 cycles, return to RUN, `redirect_count` +1 only.
- In HOLD with `held_sel`=2, `exception_WB`=1 -> sel=5, re-latched, `redirect_count` +1.
- `stall_ext`=1, no redirect -> sel=4, `stall_IF`=1, `kill_IF`=0; `eret_WB`+`jal_DX` together -> sel=6.
- `reset_n` low mid-HOLD -> outputs return to reset values immediately; `redirect_count`=0.
